// File: rtl/cdb_receiver_pkg.sv
// Shared widths for the common data bus listener: ROB label/value sizes and
// the default buffering depth.
package cdb_receiver_pkg;

    localparam int CDB_ROB_ID_WIDTH    = 4;
    localparam int CDB_VAL_WIDTH       = 32;
    localparam int CDB_LAB_INVALID_BIT = CDB_ROB_ID_WIDTH;
    localparam int CDB_DEPTH           = 8;

endpackage

// File: rtl/cdb_fifo_2w1r.sv
// Generic circular buffer with two in-order write ports and one FWFT read port.
// Writes are accepted port 0 first and only into space left after this cycle's read.
module cdb_fifo_2w1r #(
    parameter  int DEPTH = 8,
    parameter  int W     = 36,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_wr0_en,
    input  logic [W-1:0]     i_wr0_data,
    input  logic             i_wr1_en,
    input  logic [W-1:0]     i_wr1_data,
    input  logic             i_rd_en,
    output logic [W-1:0]     o_rd_data,
    output logic [PTR_W:0]   o_count,
    output logic             o_drop
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_pop;
    logic [PTR_W+1:0] w_free;
    logic [PTR_W+1:0] w_need1;
    logic             w_acc0;
    logic             w_acc1;
    logic [PTR_W:0]   w_n_acc;
    logic [PTR_W-1:0] w_tail1;

    // Space freed by this cycle's read is usable by this cycle's writes.
    assign w_pop   = i_rd_en && (r_count != '0);
    assign w_free  = (PTR_W+2)'(DEPTH) - {1'b0, r_count} + (PTR_W+2)'(w_pop);
    assign w_need1 = i_wr0_en ? (PTR_W+2)'(2) : (PTR_W+2)'(1);
    assign w_acc0  = i_wr0_en && (w_free >= (PTR_W+2)'(1));
    assign w_acc1  = i_wr1_en && (w_free >= w_need1);
    assign w_n_acc = (PTR_W+1)'(w_acc0) + (PTR_W+1)'(w_acc1);
    assign w_tail1 = r_tail + PTR_W'(w_acc0);
    assign o_drop  = (i_wr0_en && !w_acc0) || (i_wr1_en && !w_acc1);

    assign o_rd_data = r_mem[r_head];
    assign o_count   = r_count;

    // NOTE: storage is reset too, so the read port never shows X while empty.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_en) begin
            if (i_clr) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_acc0) r_mem[r_tail]  <= i_wr0_data;
                if (w_acc1) r_mem[w_tail1] <= i_wr1_data;
                r_tail  <= r_tail + PTR_W'(w_n_acc);
                r_head  <= r_head + PTR_W'(w_pop);
                r_count <= r_count + w_n_acc - (PTR_W+1)'(w_pop);
            end
        end
    end

endmodule

// File: rtl/cdb_receiver.sv
// Captures RS and LSB broadcasts into an ordered buffer and hands them one at a
// time to a single consumer; labels with the invalid bit set are ignored.
module cdb_receiver
    import cdb_receiver_pkg::*;
#(
    parameter  int ROB_ID_WIDTH = CDB_ROB_ID_WIDTH,
    parameter  int VAL_WIDTH    = CDB_VAL_WIDTH,
    parameter  int DEPTH        = CDB_DEPTH,
    localparam int PTR_W        = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    rs_cdb_en,
    input  logic [ROB_ID_WIDTH:0]   rs_cdb2lab,
    input  logic [VAL_WIDTH-1:0]    rs_cdb2val,
    input  logic                    lsb_cdb_en,
    input  logic [ROB_ID_WIDTH:0]   lsb_cdb2lab,
    input  logic [VAL_WIDTH-1:0]    lsb_cdb2val,
    output logic                    out_valid,
    output logic [ROB_ID_WIDTH-1:0] out_lab,
    output logic [VAL_WIDTH-1:0]    out_val,
    input  logic                    out_ready,
    output logic [PTR_W:0]          count,
    output logic                    overflow
);

    localparam int LAB_INVALID_BIT = ROB_ID_WIDTH;
    localparam int ENT_W           = ROB_ID_WIDTH + VAL_WIDTH;

    logic             w_rs_push;
    logic             w_lsb_push;
    logic             w_pop;
    logic             w_drop;
    logic [ENT_W-1:0] w_head_data;
    logic [PTR_W:0]   w_count;
    logic             r_overflow;

    assign w_rs_push  = rs_cdb_en  && !rs_cdb2lab[LAB_INVALID_BIT];
    assign w_lsb_push = lsb_cdb_en && !lsb_cdb2lab[LAB_INVALID_BIT];
    assign w_pop      = out_valid && out_ready && rdy_in;

    cdb_fifo_2w1r #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_in     (rst_in),
        .i_en       (rdy_in),
        .i_clr      (flush),
        .i_wr0_en   (w_rs_push),
        .i_wr0_data ({rs_cdb2lab[ROB_ID_WIDTH-1:0], rs_cdb2val}),
        .i_wr1_en   (w_lsb_push),
        .i_wr1_data ({lsb_cdb2lab[ROB_ID_WIDTH-1:0], lsb_cdb2val}),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_head_data),
        .o_count    (w_count),
        .o_drop     (w_drop)
    );

    // A flush discards this cycle's broadcasts, so they can not count as dropped.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_overflow <= 1'b0;
        end else if (rdy_in && !flush && w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign count     = w_count;
    assign out_valid = (w_count != '0);
    assign out_lab   = w_head_data[ENT_W-1 -: ROB_ID_WIDTH];
    assign out_val   = w_head_data[VAL_WIDTH-1:0];
    assign overflow  = r_overflow;

endmodule
